// File: rtl/rob_port_arbiter.sv
// rob_port_arbiter: shares the reorder_buffer AR/R slave port between NUM_REQ
// requesters. It allocates 4-bit IDs from a free bitmap, grants requesters
// round-robin, and routes returning R beats back to the owner of each ID.
module rob_port_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_REQ    = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_REQ-1:0]    req_arvalid_i,
   output logic [NUM_REQ-1:0]    req_arready_o,
   output logic [3:0]            req_arid_o,
   output logic [DATA_WIDTH-1:0] req_rdata_o,
   output logic [3:0]            req_rid_o,
   output logic [NUM_REQ-1:0]    req_rvalid_o,
   input  logic [NUM_REQ-1:0]    req_rready_i,
   output logic [3:0]            m_arid_o,
   output logic                  m_arvalid_o,
   input  logic                  m_arready_i,
   input  logic [DATA_WIDTH-1:0] m_rdata_i,
   input  logic [3:0]            m_rid_i,
   input  logic                  m_rvalid_i,
   output logic                  m_rready_o,
   output logic [4:0]            outstanding_o,
   output logic                  unexpected_rid_o
);

   localparam logic [1:0] LAST_RST = 2'(NUM_REQ - 1);

   logic [15:0]      free_q, free_d;
   logic [15:0][1:0] owner_q, owner_d;
   logic [1:0]       last_q, last_d;
   logic             arvalid_q, arvalid_d;
   logic [3:0]       arid_q, arid_d;
   logic [4:0]       outst_q, outst_d;
   logic             unexp_q, unexp_d;

   logic       found;
   logic [1:0] win;
   logic [3:0] alloc_id;
   logic       grant;
   logic [1:0] r_owner;
   logic       r_owned;
   logic       r_fire;

   // Round-robin search starting just after the last winner.
   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         if (!found && req_arvalid_i[(int'(last_q) + i) % NUM_REQ]) begin
            found = 1'b1;
            win   = 2'((int'(last_q) + i) % NUM_REQ);
         end
      end
   end

   // Lowest free ID, taken from the registered bitmap only, so an ID freed
   // this cycle cannot be handed out until the next one.
   always_comb begin
      alloc_id = '0;
      for (int i = 15; i >= 0; i--) begin
         if (free_q[i]) alloc_id = 4'(i);
      end
   end

   assign grant = (!arvalid_q || m_arready_i) && found && (free_q != '0);

   // Grant is presented to the winner in the same cycle it is decided.
   always_comb begin
      req_arready_o = '0;
      if (grant) req_arready_o[win] = 1'b1;
   end

   assign req_arid_o = grant ? alloc_id : 4'd0;

   // R beats pass straight through; an unowned ID is swallowed.
   assign r_owner = owner_q[m_rid_i];
   assign r_owned = !free_q[m_rid_i];
   assign r_fire  = m_rvalid_i && r_owned && req_rready_i[r_owner];

   always_comb begin
      req_rvalid_o = '0;
      if (r_owned) req_rvalid_o[r_owner] = m_rvalid_i;
   end

   // Unowned beats are always accepted so they cannot block the return path.
   assign m_rready_o  = r_owned ? req_rready_i[r_owner] : m_rvalid_i;
   assign req_rdata_o = m_rdata_i;
   assign req_rid_o   = m_rid_i;

   // Next state for the ID pool, AR output register and counters.
   always_comb begin
      free_d    = free_q;
      owner_d   = owner_q;
      last_d    = last_q;
      arvalid_d = arvalid_q;
      arid_d    = arid_q;
      outst_d   = outst_q;
      unexp_d   = unexp_q;
      if (r_fire) free_d[m_rid_i] = 1'b1;
      if (grant) begin
         free_d[alloc_id]  = 1'b0;
         owner_d[alloc_id] = win;
         last_d            = win;
         arvalid_d         = 1'b1;
         arid_d            = alloc_id;
      end else if (m_arready_i) begin
         arvalid_d = 1'b0;
      end
      if (grant && !r_fire)      outst_d = outst_q + 5'd1;
      else if (!grant && r_fire) outst_d = outst_q - 5'd1;
      if (m_rvalid_i && !r_owned) unexp_d = 1'b1;
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         free_q    <= '1;
         owner_q   <= '0;
         last_q    <= LAST_RST;
         arvalid_q <= 1'b0;
         arid_q    <= '0;
         outst_q   <= '0;
         unexp_q   <= 1'b0;
      end else begin
         free_q    <= free_d;
         owner_q   <= owner_d;
         last_q    <= last_d;
         arvalid_q <= arvalid_d;
         arid_q    <= arid_d;
         outst_q   <= outst_d;
         unexp_q   <= unexp_d;
      end
   end

   assign m_arvalid_o      = arvalid_q;
   assign m_arid_o         = arid_q;
   assign outstanding_o    = outst_q;
   assign unexpected_rid_o = unexp_q;

endmodule
